// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder
// Byte buffer and sequencer placed directly upstream of the UART transmitter.
// Bytes from the command/message logic are queued in a 2**ADDR_W entry
// synchronous FIFO. Each queued byte goes to the transmitter as one tx_start
// pulse, with tx_data held stable. The next byte is sent only after
// tx_done_tick. When data is waiting, the next start follows the done tick
// with no idle gap.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   wr_en_i        write strobe, one byte per cycle while high
//   wr_data_i      byte to enqueue
//   clr_ovf_i      synchronous clear of the sticky overflow flag
//   tx_done_tick_i one-cycle pulse from the transmitter at end of stop bit
//   tx_start_o     one-cycle registered start pulse to the transmitter
//   tx_data_o      registered byte for the transmitter, held until next pop
//   full_o         FIFO holds 2**ADDR_W bytes
//   empty_o        FIFO holds no bytes
//   count_o        number of stored bytes, 0..2**ADDR_W
//   busy_o         a byte is in flight (state WAIT)
//   overflow_o     sticky, set when a write is dropped because the FIFO is full
module uart_tx_fifo_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DBIT-1:0]   wr_data_i,
    input  logic              clr_ovf_i,
    input  logic              tx_done_tick_i,
    output logic              tx_start_o,
    output logic [DBIT-1:0]   tx_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic                tx_start_q;
    logic [DBIT-1:0]     tx_data_q;
    logic [DBIT-1:0]     mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                do_write, do_pop, drop;

    // full/empty come from the registered count only. A same-cycle pop
    // therefore never makes room for a write that arrives while full.
    assign full_o  = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);

    // The start of a byte and its pop are the same event. In IDLE, any
    // stored byte starts at once. In WAIT, a byte starts only on the
    // transmitter's done tick, so at most one byte is ever outstanding.
    always_comb begin
        do_write   = wr_en_i && !full_o;
        drop       = wr_en_i && full_o;
        do_pop     = !empty_o && ((state_q == S_IDLE) || tx_done_tick_i);
        wr_ptr_d   = do_write ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop   ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({do_write, do_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // A dropped write takes priority over a clear in the same cycle.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    // Storage has no reset; its contents are don't-care once count is zero.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Sequencer FSM. A done tick that arrives while the FIFO is empty returns
    // to IDLE, even if a write lands in that same cycle. That byte is then
    // sent from IDLE on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= do_pop;
            if (do_pop) begin
                tx_data_q <= mem_q[rd_ptr_q];
                state_q   <= S_WAIT;
            end else if ((state_q == S_WAIT) && tx_done_tick_i) begin
                state_q   <= S_IDLE;
            end
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign count_o    = count_q;
    assign busy_o     = (state_q == S_WAIT);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Testbench for uart_tx_fifo_feeder: directed scenarios with hand-computed
// expectations, one task per feature, run in sequence.
module tb_uart_tx_fifo_feeder;

    logic       clk = 1'b0;
    logic       rstN;
    logic       wrEn;
    logic [7:0] wrData;
    logic       clrOvf;
    logic       txDoneTick;
    logic       txStart;
    logic [7:0] txData;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_feeder #(.DBIT(8), .ADDR_W(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .wr_en_i        (wrEn),
        .wr_data_i      (wrData),
        .clr_ovf_i      (clrOvf),
        .tx_done_tick_i (txDoneTick),
        .tx_start_o     (txStart),
        .tx_data_o      (txData),
        .full_o         (full),
        .empty_o        (empty),
        .count_o        (count),
        .busy_o         (busy),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; wrEn = 1'b0; wrData = 8'h00; clrOvf = 1'b0; txDoneTick = 1'b0;
        tick(); tick();
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start got=%0b exp=0", txStart); end
        checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h exp=00", txData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%0b exp=0", full); end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        wrEn = 1'b1; wrData = 8'h41;
        tick();
        wrEn = 1'b0;
        checks++; if (empty !== 1'b0) begin failures++; $display("[TB] FAIL single_empty_n1 got=%0b exp=0", empty); end
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL single_start_n1 got=%0b exp=0", txStart); end
        tick();
        checks++; if (txStart !== 1'b1) begin failures++; $display("[TB] FAIL single_start_n2 got=%0b exp=1", txStart); end
        checks++; if (txData !== 8'h41) begin failures++; $display("[TB] FAIL single_data got=%h exp=41", txData); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%0b exp=1", busy); end
        tick();
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse_width got=%0b exp=0", txStart); end
        checks++; if (txData !== 8'h41) begin failures++; $display("[TB] FAIL single_data_held got=%h exp=41", txData); end
        repeat (18) tick();
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_done_busy got=%0b exp=0", busy); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL single_done_empty got=%0b exp=1", empty); end
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL single_done_start got=%0b exp=0", txStart); end
    endtask

    task automatic test_burst();
        logic [7:0] bytes [4];
        int         peak;
        logic [7:0] first;
        bit         seen;
        bit         extra;
        bytes[0] = 8'h48; bytes[1] = 8'h49; bytes[2] = 8'h0D; bytes[3] = 8'h0A;
        peak = 0; first = 8'h00; seen = 1'b0; extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wrEn = 1'b1; wrData = bytes[i];
            tick();
            if (int'(count) > peak) peak = int'(count);
            if (txStart === 1'b1) begin seen = 1'b1; first = txData; end
        end
        wrEn = 1'b0;
        checks++; if (peak != 3) begin failures++; $display("[TB] FAIL burst_peak got=%0d exp=3", peak); end
        checks++; if (!(seen && first === 8'h48)) begin failures++; $display("[TB] FAIL burst_first seen=%0b got=%h exp=48", seen, first); end
        repeat (3) begin
            tick();
            if (txStart === 1'b1) extra = 1'b1;
        end
        checks++; if (extra) begin failures++; $display("[TB] FAIL burst_no_extra_start got=1 exp=0"); end
        for (int k = 1; k < 4; k++) begin
            txDoneTick = 1'b1;
            tick();
            txDoneTick = 1'b0;
            checks++; if (txStart !== 1'b1) begin failures++; $display("[TB] FAIL burst_start_%0d got=%0b exp=1", k, txStart); end
            checks++; if (txData !== bytes[k]) begin failures++; $display("[TB] FAIL burst_data_%0d got=%h exp=%h", k, txData, bytes[k]); end
            checks++; if (count !== 5'(3 - k)) begin failures++; $display("[TB] FAIL burst_count_%0d got=%0d exp=%0d", k, count, 3 - k); end
            tick();
            checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL burst_pulse_%0d got=%0b exp=0", k, txStart); end
        end
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL burst_end_busy got=%0b exp=0", busy); end
        checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL burst_end_count got=%0d exp=0", count); end
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL burst_end_start got=%0b exp=0", txStart); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i <= 16; i++) begin
            wrEn = 1'b1; wrData = 8'(i);
            tick();
        end
        wrEn = 1'b0;
        checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL full_count got=%0d exp=16", count); end
        checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL full_flag got=%0b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_no_ovf got=%0b exp=0", overflow); end
        checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL full_inflight got=%h exp=00", txData); end
        wrEn = 1'b1; wrData = 8'hFF;
        tick();
        wrEn = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%0b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=16", count); end
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%0b exp=0", overflow); end
        wrEn = 1'b1; wrData = 8'hFE; clrOvf = 1'b1;
        tick();
        wrEn = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set_wins got=%0b exp=1", overflow); end
        tick();
        clrOvf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear2 got=%0b exp=0", overflow); end
    endtask

    task automatic test_simultaneous();
        bit seen;
        wrEn = 1'b1; wrData = 8'hEE; txDoneTick = 1'b1;
        tick();
        wrEn = 1'b0; txDoneTick = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL simul_ovf got=%0b exp=1", overflow); end
        checks++; if (count !== 5'd15) begin failures++; $display("[TB] FAIL simul_count got=%0d exp=15", count); end
        checks++; if (txStart !== 1'b1 || txData !== 8'h01) begin failures++; $display("[TB] FAIL simul_pop start=%0b data=%h exp=1/01", txStart, txData); end
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            txDoneTick = 1'b1;
            tick();
            txDoneTick = 1'b0;
            checks++; if (txStart !== 1'b1 || txData !== 8'(k)) begin failures++; $display("[TB] FAIL drain_%0d start=%0b data=%h exp=1/%h", k, txStart, txData, 8'(k)); end
            checks++; if (count !== 5'(16 - k)) begin failures++; $display("[TB] FAIL drain_count_%0d got=%0d exp=%0d", k, count, 16 - k); end
            tick();
        end
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle got=%0b exp=0", busy); end
        seen = 1'b0;
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        if (txStart === 1'b1) seen = 1'b1;
        repeat (4) begin
            tick();
            if (txStart === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL spurious_done got=1 exp=0"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL spurious_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_done_with_write();
        wrEn = 1'b1; wrData = 8'h55;
        tick();
        wrEn = 1'b0;
        tick();
        repeat (3) tick();
        wrEn = 1'b1; wrData = 8'h66; txDoneTick = 1'b1;
        tick();
        wrEn = 1'b0; txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0 || empty !== 1'b0 || txStart !== 1'b0) begin failures++; $display("[TB] FAIL dw_idle busy=%0b empty=%0b start=%0b exp=0/0/0", busy, empty, txStart); end
        tick();
        checks++; if (txStart !== 1'b1 || txData !== 8'h66 || busy !== 1'b1) begin failures++; $display("[TB] FAIL dw_send start=%0b data=%h busy=%0b exp=1/66/1", txStart, txData, busy); end
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL dw_end got=%0b exp=0", busy); end
    endtask

    // Emulated transmitter: done tick 8 cycles after each start.
    task automatic test_pointer_wrap();
        logic [7:0] rx [$];
        int         wrIdx;
        int         timer;
        int         cyc;
        bit         multi;
        wrIdx = 0; timer = 0; cyc = 0; multi = 1'b0;
        while (rx.size() < 40 && cyc < 2000) begin
            if (txStart === 1'b1) begin
                if (timer != 0) multi = 1'b1;
                rx.push_back(txData);
                timer = 8;
            end
            txDoneTick = (timer == 1);
            if (timer > 0) timer--;
            if (cyc % 7 == 0 && wrIdx < 40) begin
                wrEn = 1'b1; wrData = 8'(wrIdx); wrIdx++;
            end else begin
                wrEn = 1'b0;
            end
            tick();
            cyc++;
        end
        wrEn = 1'b0; txDoneTick = 1'b0;
        checks++; if (rx.size() != 40) begin failures++; $display("[TB] FAIL wrap_received got=%0d exp=40", rx.size()); end
        foreach (rx[i]) begin
            checks++; if (rx[i] !== 8'(i)) begin failures++; $display("[TB] FAIL wrap_byte_%0d got=%h exp=%h", i, rx[i], 8'(i)); end
        end
        checks++; if (multi) begin failures++; $display("[TB] FAIL wrap_outstanding got=2 exp=1"); end
        repeat (6) tick();
        txDoneTick = 1'b1;
        tick();
        txDoneTick = 1'b0;
        checks++; if (busy !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL wrap_end busy=%0b count=%0d ovf=%0b exp=0/0/0", busy, count, overflow); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 6; i++) begin
            wrEn = 1'b1; wrData = 8'(8'hA0 + i);
            tick();
        end
        wrEn = 1'b0;
        checks++; if (count !== 5'd5 || busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_precond count=%0d busy=%0b exp=5/1", count, busy); end
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_fifo count=%0d empty=%0b full=%0b exp=0/1/0", count, empty, full); end
        checks++; if (busy !== 1'b0 || txStart !== 1'b0 || txData !== 8'h00 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_out busy=%0b start=%0b data=%h ovf=%0b exp=0/0/00/0", busy, txStart, txData, overflow); end
        tick();
        rstN = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (txStart === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL mid_after_release_start got=1 exp=0"); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_after_release empty=%0b busy=%0b exp=1/0", empty, busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_full_overflow();
        test_simultaneous();
        test_done_with_write();
        test_pointer_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte buffer and sequencer that sits directly upstream of the UART transmitter.
- Accepts ASCII bytes from the command/message logic into a synchronous FIFO.
- Issues one tx_start pulse per byte with din held stable, waits for tx_done_tick, then sends the next byte.
- Keeps the ESP32 link fully back-to-back when the FIFO holds data.

Parameters:
- DBIT, 8, data width in bits; matches the transmitter's DBIT.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- wr_en  input  1  write strobe; one byte is offered per cycle while high.
- wr_data  input  DBIT  byte to enqueue.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- tx_done_tick  input  1  1-clock pulse from the transmitter at the end of the stop bit.
- tx_start  output  1  1-clock pulse to the transmitter, registered.
- tx_data  output  DBIT  byte driven to the transmitter din, registered, held until the next pop.
- full  output  1  FIFO count == 2**ADDR_W.
- empty  output  1  FIFO count == 0.
- count  output  ADDR_W+1  number of bytes stored, 0..16.
- busy  output  1  high while a byte is in flight (state WAIT).
- overflow  output  1  sticky flag; set when a write is dropped.

Behaviour:
- Reset (reset=0, async) sets:
  - tx_start=0, tx_data=0, busy=0, overflow=0.
  - count=0, empty=1, full=0.
  - read and write pointers = 0, state=IDLE.
  - Any in-flight byte is abandoned. The FIFO is emptied and its stored contents are don't-care.
- FIFO storage:
  - Circular buffer; read and write pointers are ADDR_W bits and wrap 15->0 naturally.
  - count is a separate register. full and empty are decoded from the registered count, not from same-cycle events.
- Write:
  - When wr_en=1 and full=0, write wr_data at wr_ptr and increment wr_ptr.
  - When wr_en=1 and full=1, drop the byte, set overflow=1, and leave pointers unchanged. This applies even if a pop happens in the same cycle.
- Pop:
  - Happens only on the edge where tx_start is set.
  - Loads tx_data from mem[rd_ptr] and increments rd_ptr.
- Count update:
  - Write and pop in the same cycle: count unchanged.
  - Write only: +1.
  - Pop only: -1.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - If clr_ovf and a dropped write occur in the same cycle, set wins.
- FSM with 2 states:
  - IDLE: busy=0. If empty=0, set tx_start=1 for exactly one cycle, pop, and go to WAIT.
  - WAIT: busy=1, tx_start=0. On tx_done_tick:
    - if empty=0, pulse tx_start, pop, and stay in WAIT (back-to-back, zero idle gap);
    - if empty=1, go to IDLE.
  - tx_done_tick received in IDLE is ignored.
- Latency:
  - wr_en into an empty FIFO in IDLE at cycle N: empty=0 in N+1, tx_start=1 and tx_data valid in N+2.
  - tx_done_tick at cycle M with data queued: next tx_start in M+1. The transmitter is back in its idle state by then.
- tx_data is valid from the tx_start cycle onward. It does not change until the next pop, so the transmitter can latch it on its tx_start cycle.
- Never more than one outstanding byte: at most one tx_start between consecutive tx_done_ticks.
- Write into an empty FIFO in the same cycle as tx_done_tick in WAIT:
  - The FIFO is still empty, so the FSM goes to IDLE.
  - The byte is sent from IDLE with 2-cycle latency.

Test Plan:
- Single byte: reset, write 0x41 at cycle 10 -> tx_start pulse at cycle 12 with tx_data=0x41, busy=1. Feed tx_done_tick 20 cycles later -> busy=0, empty=1.
- Burst: write 0x48,0x49,0x0D,0x0A on consecutive cycles -> count peaks at 3 (one already popped). Each tx_done_tick yields tx_start on the next cycle with data in that order. After the 4th done -> IDLE, count=0.
- Full/overflow: hold off tx_done_tick and write 17 bytes 0x00..0x10 -> first byte popped, 16 stored, full=1. Write 0xFF -> dropped, overflow=1, count stays 16. clr_ovf -> overflow=0.
- Pointer wrap: stream 40 bytes through with tx_done_tick every 8 cycles -> output sequence exactly equals input sequence 0..39, no loss or duplication.
- Simultaneous: at full, assert wr_en with tx_done_tick (pop) -> write dropped, overflow=1, count=15. Spurious tx_done_tick in IDLE -> no tx_start.
- Reset mid-operation: assert reset=0 with 5 bytes queued and a byte in flight -> all outputs at reset values immediately. After release with no writes -> tx_start stays 0.
